// File: rtl/lfsr_draw_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_draw_arbiter_pkg
// Brief    : Shared types and constants for the LFSR draw arbiter.
// Revision : 1.0
// ============================================================================
package lfsr_draw_arbiter_pkg;

  localparam int LFSR_W = 5;

  // Feedback taps: bits 4, 2 and 1.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 5'b10110;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEED  = 2'd1,
    ST_STEP  = 2'd2,
    ST_GRANT = 2'd3
  } state_t;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_draw_arbiter_lfsr5_core.sv
`default_nettype none
// ============================================================================
// Module   : lfsr5_core
// Brief    : 5-bit Fibonacci LFSR register with seed load and single step.
// Revision : 1.0
// ============================================================================
module lfsr5_core
  import lfsr_draw_arbiter_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 5'b00001
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_load,
  input  logic [LFSR_W-1:0] i_load_val,
  input  logic              i_step,
  output logic [LFSR_W-1:0] o_value
);

  logic [LFSR_W-1:0] r_lfsr;
  logic [LFSR_W-1:0] w_load_fix;

  // The all-zero state is a lock-up point, so a zero seed becomes 1.
  assign w_load_fix = (i_load_val == '0) ? LFSR_W'(1) : i_load_val;

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_lfsr <= SEED;
    end else if (i_load) begin
      r_lfsr <= w_load_fix;
    end else if (i_step) begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  assign o_value = r_lfsr;

endmodule
`default_nettype wire

// File: rtl/lfsr_draw_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_draw_arbiter
// Brief    : Round-robin arbiter handing fresh 5-bit LFSR draws to N_REQ users.
// Revision : 1.0
// ============================================================================
module lfsr_draw_arbiter
  import lfsr_draw_arbiter_pkg::*;
#(
  parameter int                N_REQ = 4,
  parameter int                STEPS = 5,
  parameter logic [LFSR_W-1:0] SEED  = 5'b00001
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic [N_REQ-1:0]  i_req,
  input  logic              i_seed_load,
  input  logic [LFSR_W-1:0] i_seed,
  output logic [N_REQ-1:0]  o_gnt,
  output logic              o_valid,
  output logic [LFSR_W-1:0] o_data,
  output logic              o_busy
);

  localparam int c_PTR_W = $clog2(N_REQ);
  localparam int c_CNT_W = 4;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_PTR_W-1:0]   r_ptr;
  logic [c_PTR_W-1:0]   r_win;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 r_pending;
  logic [LFSR_W-1:0]    r_seed;

  logic                 w_load;
  logic                 w_step;
  logic                 w_arb;
  logic [LFSR_W-1:0]    w_lfsr;

  logic [2*N_REQ-1:0]   w_req2;
  logic [N_REQ-1:0]     w_rot;
  logic [c_PTR_W:0]     w_off;
  logic [c_PTR_W:0]     w_sum;
  logic [c_PTR_W-1:0]   w_win;
  logic [c_PTR_W-1:0]   w_ptr_inc;
  logic [N_REQ-1:0]     w_gnt;

  lfsr5_core #(
    .SEED (SEED)
  ) u_lfsr (
    .i_Clk      (i_Clk),
    .i_Rst      (i_Rst),
    .i_load     (w_load),
    .i_load_val (r_seed),
    .i_step     (w_step),
    .o_value    (w_lfsr)
  );

  // Rotate requests so the pointer position lands at bit 0, then take the
  // lowest set bit and rotate the offset back.
  assign w_req2 = {i_req, i_req};
  assign w_rot  = w_req2[{1'b0, r_ptr} +: N_REQ];

  always_comb begin
    w_off = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off = (c_PTR_W + 1)'(k);
      end
    end
  end

  assign w_sum = {1'b0, r_ptr} + w_off;
  assign w_win = (w_sum >= (c_PTR_W + 1)'(N_REQ)) ?
                 c_PTR_W'(w_sum - (c_PTR_W + 1)'(N_REQ)) : c_PTR_W'(w_sum);

  assign w_ptr_inc = (r_win == c_PTR_W'(N_REQ - 1)) ? '0 : r_win + 1'b1;

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A pulse seen in IDLE goes straight to SEED; otherwise the registered
  // pending flag carries it to the next IDLE. Seeds outrank requests.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_arb       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_pending || i_seed_load) begin
          w_state_nxt = ST_SEED;
        end else if (|i_req) begin
          w_state_nxt = ST_STEP;
          w_arb       = 1'b1;
        end
      end
      ST_SEED: begin
        w_load      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      ST_STEP: begin
        w_step = 1'b1;
        if (r_cnt == c_CNT_W'(1)) begin
          w_state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_ptr     <= '0;
      r_win     <= '0;
      r_cnt     <= '0;
      r_pending <= 1'b0;
      r_seed    <= '0;
    end else begin
      if (w_arb) begin
        r_win <= w_win;
        r_cnt <= c_CNT_W'(STEPS);
      end else if (r_state == ST_STEP) begin
        r_cnt <= r_cnt - c_CNT_W'(1);
      end

      if (r_state == ST_GRANT) begin
        r_ptr <= w_ptr_inc;
      end

      // A pulse during SEED re-arms the flag: the older seed loads now and
      // the newer one on the following IDLE.
      if (i_seed_load) begin
        r_pending <= 1'b1;
        r_seed    <= i_seed;
      end else if (r_state == ST_SEED) begin
        r_pending <= 1'b0;
      end
    end
  end

  always_comb begin
    w_gnt        = '0;
    w_gnt[r_win] = (r_state == ST_GRANT);
  end

  assign o_gnt   = w_gnt;
  assign o_valid = (r_state == ST_GRANT);
  assign o_data  = (r_state == ST_GRANT) ? w_lfsr : '0;
  assign o_busy  = (r_state != ST_IDLE);

endmodule
`default_nettype wire
